// File: rtl/cpu_wb_arbiter_pkg.sv
// Shared CPU constants and the buffered MDU result type for the writeback arbiter.
package cpu_wb_arbiter_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  wd;
    } wb_entry_t;

endpackage

// File: rtl/cpu_wb_fifo.sv
// In-order MDU result buffer with a parallel {valid, rd} view of every slot for hazard compare.
module cpu_wb_fifo
    import cpu_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         push_i,
    input  logic [REG_W-1:0]             push_rd_i,
    input  logic [XLEN-1:0]              push_wd_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [REG_W-1:0]             head_rd_o,
    output logic [XLEN-1:0]              head_wd_o,
    output logic [DEPTH-1:0]             ent_valid_o,
    output logic [DEPTH-1:0][REG_W-1:0]  ent_rd_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    wb_entry_t     mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= '{rd: push_rd_i, wd: push_wd_i};
    end

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign head_rd_o = mem_q[rd_ptr_q].rd;
    assign head_wd_o = mem_q[rd_ptr_q].wd;

    // A slot is live when its distance from the read pointer is below the fill count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        logic [PW-1:0] off;
        assign off            = PW'(i) - rd_ptr_q;
        assign ent_valid_o[i] = ({1'b0, off} < count_q);
        assign ent_rd_o[i]    = mem_q[i].rd;
    end

endmodule

// File: rtl/cpu_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered MDU results,
// with a starvation stall and RAW/WAW hazard flags against buffered entries.
module cpu_wb_arbiter
    import cpu_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_we,
    input  logic [REG_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]  pipe_wd,
    input  logic             mdu_valid,
    output logic             mdu_ready,
    input  logic [REG_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]  mdu_wd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             hazard,
    output logic             stall,
    output logic             rf_we3,
    output logic [REG_W-1:0] rf_a3,
    output logic [XLEN-1:0]  rf_wd3
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic                        fifo_full, fifo_empty, enq, pop;
    logic [REG_W-1:0]            head_rd;
    logic [XLEN-1:0]             head_wd;
    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH-1:0][REG_W-1:0] ent_rd;
    logic                        pipe_req, raw, waw, fifo_wr, pipe_wr;
    logic [SW-1:0]               starve_cnt_q, starve_cnt_d;

    cpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .push_i      (enq),
        .push_rd_i   (mdu_rd),
        .push_wd_i   (mdu_wd),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_rd_o   (head_rd),
        .head_wd_o   (head_wd),
        .ent_valid_o (ent_valid),
        .ent_rd_o    (ent_rd)
    );

    // Results to x0 are acknowledged but never buffered.
    assign mdu_ready = rst_n && !fifo_full;
    assign enq       = mdu_valid && mdu_ready && (mdu_rd != ZERO_REG);
    assign pipe_req  = pipe_we && (pipe_rd != ZERO_REG);

    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                if (rs1 != ZERO_REG && rs1 == ent_rd[i]) raw = 1'b1;
                if (rs2 != ZERO_REG && rs2 == ent_rd[i]) raw = 1'b1;
                if (pipe_req && pipe_rd == ent_rd[i])    waw = 1'b1;
            end
        end
    end

    assign hazard = raw || waw;
    assign stall  = !fifo_empty && (starve_cnt_q == STARVE_MAX);

    always_comb begin
        fifo_wr = 1'b0;
        pipe_wr = 1'b0;
        if (stall)                fifo_wr = 1'b1;
        else if (pipe_req && !waw) pipe_wr = 1'b1;
        else if (!fifo_empty)     fifo_wr = 1'b1;
    end

    assign pop    = fifo_wr && rst_n;
    assign rf_we3 = rst_n && (fifo_wr || pipe_wr);
    assign rf_a3  = fifo_wr ? head_rd : (pipe_wr ? pipe_rd : ZERO_REG);
    assign rf_wd3 = fifo_wr ? head_wd : (pipe_wr ? pipe_wd : '0);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (pop || fifo_empty)             starve_cnt_d = '0;
        else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) starve_cnt_q <= '0;
        else        starve_cnt_q <= starve_cnt_d;
    end

endmodule
